// File: rtl/register_file_param.sv
// Parametrised register file for the Master FPGA link: RW / RO / W1C registers,
// registered readback with a valid pulse, write strobes, optional auto-increment and access-error flags.
module register_file_param #(
    parameter int                         NUM_REGS = 32,
    parameter int                         DATA_W   = 32,
    parameter int                         ADDR_W   = $clog2(NUM_REGS),
    parameter logic [NUM_REGS-1:0]        RO_MASK  = '0,
    parameter logic [NUM_REGS-1:0]        W1C_MASK = '0,
    parameter logic [NUM_REGS*DATA_W-1:0] RST_VALS = '0,
    parameter bit                         AUTO_INC = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [DATA_W-1:0]            rx_data,
    input  logic                         reg_num_le,
    input  logic                         wr_en,
    input  logic                         rd_en,
    output logic [DATA_W-1:0]            tx_data,
    output logic                         rd_valid,
    output logic                         illegal_reg_num,
    output logic                         acc_err,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          wr_stb,
    input  logic [NUM_REGS*DATA_W-1:0]   ro_data,
    input  logic [NUM_REGS*DATA_W-1:0]   hw_set
);

    // One extra bit so NUM_REGS itself is representable even when NUM_REGS == 2**DATA_W.
    localparam logic [DATA_W:0] NUM_REGS_X = (DATA_W+1)'(NUM_REGS);

    logic [DATA_W-1:0]   reg_num;
    logic [ADDR_W-1:0]   idx;
    logic                legal;
    logic                sel_ro;
    logic [DATA_W-1:0]   rd_val;
    logic [NUM_REGS-1:0] sel_dec;
    logic [NUM_REGS-1:0] wr_hit;
    logic [DATA_W-1:0]   q [NUM_REGS];

    assign illegal_reg_num = ({1'b0, reg_num} >= NUM_REGS_X);
    assign legal           = ~illegal_reg_num;
    assign idx             = reg_num[ADDR_W-1:0];

    always_comb begin
        sel_dec = '0;
        sel_ro  = 1'b0;
        rd_val  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (legal && (idx == ADDR_W'(i))) begin
                sel_dec[i] = 1'b1;
                sel_ro     = RO_MASK[i];
                rd_val     = RO_MASK[i] ? ro_data[i*DATA_W +: DATA_W] : q[i];
            end
        end
    end

    assign wr_hit = sel_dec & ~RO_MASK & {NUM_REGS{wr_en}};

    // Register storage. RO entries hold zero; W1C entries OR in hw_set every cycle,
    // and the set term is applied after the clear so hardware wins a same-cycle race.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                q[i] <= RO_MASK[i] ? '0 : RST_VALS[i*DATA_W +: DATA_W];
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (RO_MASK[i]) begin
                    q[i] <= '0;
                end else if (W1C_MASK[i]) begin
                    q[i] <= (wr_hit[i] ? (q[i] & ~rx_data) : q[i]) | hw_set[i*DATA_W +: DATA_W];
                end else if (wr_hit[i]) begin
                    q[i] <= rx_data;
                end
            end
        end
    end

    always_comb begin
        reg_q = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = q[i];
        end
    end

    // rd_valid is a one-cycle pulse the cycle after each rd_en; tx_data is valid while it is
    // high and holds until the next read. There is no ready/backpressure on this interface.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reg_num  <= '0;
            tx_data  <= '0;
            rd_valid <= 1'b0;
            acc_err  <= 1'b0;
            wr_stb   <= '0;
        end else begin
            rd_valid <= rd_en;
            wr_stb   <= wr_hit;
            acc_err  <= (wr_en && (illegal_reg_num || sel_ro)) || (rd_en && illegal_reg_num);
            if (rd_en) begin
                tx_data <= rd_val;
            end
            // An explicit load always beats the auto-increment.
            if (reg_num_le) begin
                reg_num <= rx_data;
            end else if (AUTO_INC && (rd_en || wr_en) && legal) begin
                reg_num <= (idx == ADDR_W'(NUM_REGS-1)) ? '0 : reg_num + DATA_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: one AUTO_INC=0 and one AUTO_INC=1 instance
// driven by the same stimulus, outputs compared against hand-computed values.
module tb_register_file_param;

    localparam int NR = 32;
    localparam int DW = 32;
    localparam logic [NR-1:0] RO_M  = 32'h0000_0080;
    localparam logic [NR-1:0] W1C_M = 32'h0000_1000;
    localparam logic [NR*DW-1:0] RST =
          ((NR*DW)'(32'h0000_00AA) << (0*DW))
        | ((NR*DW)'(32'h0000_0011) << (1*DW))
        | ((NR*DW)'(32'd70000)     << (2*DW))
        | ((NR*DW)'(32'h0000_0066) << (6*DW))
        | ((NR*DW)'(32'h3000_0030) << (30*DW))
        | ((NR*DW)'(32'h3100_0031) << (31*DW));

    logic              clk;
    logic              reset_n;
    logic [DW-1:0]     rx_data;
    logic              reg_num_le, wr_en, rd_en;
    logic [NR*DW-1:0]  ro_data, hw_set;

    logic [DW-1:0]     tx_a, tx_b;
    logic              rdv_a, rdv_b, ill_a, ill_b, err_a, err_b;
    logic [NR*DW-1:0]  q_a, q_b;
    logic [NR-1:0]     stb_a, stb_b;

    int n_checks = 0;
    int n_pass   = 0;
    logic [31:0] exp_q[$];

    register_file_param #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(5), .RO_MASK(RO_M),
        .W1C_MASK(W1C_M), .RST_VALS(RST), .AUTO_INC(1'b0)) dut_a (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .reg_num_le(reg_num_le),
        .wr_en(wr_en), .rd_en(rd_en), .tx_data(tx_a), .rd_valid(rdv_a),
        .illegal_reg_num(ill_a), .acc_err(err_a), .reg_q(q_a), .wr_stb(stb_a),
        .ro_data(ro_data), .hw_set(hw_set));

    register_file_param #(.NUM_REGS(NR), .DATA_W(DW), .ADDR_W(5), .RO_MASK(RO_M),
        .W1C_MASK(W1C_M), .RST_VALS(RST), .AUTO_INC(1'b1)) dut_b (
        .clk(clk), .reset_n(reset_n), .rx_data(rx_data), .reg_num_le(reg_num_le),
        .wr_en(wr_en), .rd_en(rd_en), .tx_data(tx_b), .rd_valid(rdv_b),
        .illegal_reg_num(ill_b), .acc_err(err_b), .reg_q(q_b), .wr_stb(stb_b),
        .ro_data(ro_data), .hw_set(hw_set));

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic check_both(input string tag, input logic [31:0] got_a,
                              input logic [31:0] got_b, input logic [31:0] exp);
        check({tag, "_a"}, got_a, exp);
        check({tag, "_b"}, got_b, exp);
    endtask

    function automatic logic [31:0] slice(input logic [NR*DW-1:0] v, input int i);
        return v[i*DW +: DW];
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel(input logic [31:0] n);
        reg_num_le = 1'b1;
        rx_data    = n;
        tick();
        reg_num_le = 1'b0;
    endtask

    task automatic rd();
        rd_en   = 1'b1;
        rx_data = '0;
        tick();
        rd_en   = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d);
        wr_en   = 1'b1;
        rx_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset_n    = 1'b0;
        rx_data    = '0;
        reg_num_le = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        ro_data    = '0;
        hw_set     = '0;
        ro_data[7*DW +: DW] = 32'h0000_1234;
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        check_both("rst_q2", slice(q_a, 2), slice(q_b, 2), 32'd70000);
        check_both("rst_tx", tx_a, tx_b, 32'h0);
        check_both("rst_rdv", 32'(rdv_a), 32'(rdv_b), 32'h0);
        check_both("rst_stb", stb_a, stb_b, 32'h0);
        check_both("rst_ill", 32'(ill_a), 32'(ill_b), 32'h0);
        reset_n = 1'b1;
        tick();

        sel(2);
        rd();
        check_both("rd2_tx", tx_a, tx_b, 32'd70000);
        check_both("rd2_rdv", 32'(rdv_a), 32'(rdv_b), 32'h1);
        tick();
        check_both("rdv_pulse", 32'(rdv_a), 32'(rdv_b), 32'h0);
        check_both("tx_hold", tx_a, tx_b, 32'd70000);

        // RW write and strobe
        sel(5);
        wr(32'hA5A5_0001);
        check_both("rw_q5", slice(q_a, 5), slice(q_b, 5), 32'hA5A5_0001);
        check_both("rw_stb", stb_a, stb_b, 32'h0000_0020);
        tick();
        check_both("rw_stb_end", stb_a, stb_b, 32'h0);
        sel(5);
        rd();
        check_both("rw_rd", tx_a, tx_b, 32'hA5A5_0001);
        hw_set[5*DW +: DW] = 32'h0000_00F0;
        tick();
        hw_set = '0;
        check_both("rw_hwset_ign", slice(q_a, 5), slice(q_b, 5), 32'hA5A5_0001);

        // RO register and illegal register number
        sel(7);
        wr(32'hFFFF_FFFF);
        check_both("ro_wr_err", 32'(err_a), 32'(err_b), 32'h1);
        check_both("ro_wr_stb", stb_a, stb_b, 32'h0);
        check_both("ro_q7", slice(q_a, 7), slice(q_b, 7), 32'h0);
        tick();
        check_both("ro_err_end", 32'(err_a), 32'(err_b), 32'h0);
        sel(7);
        rd();
        check_both("ro_rd", tx_a, tx_b, 32'h0000_1234);
        check_both("ro_rd_err", 32'(err_a), 32'(err_b), 32'h0);
        sel(40);
        check_both("ill_lvl", 32'(ill_a), 32'(ill_b), 32'h1);
        rd();
        check_both("ill_rd_tx", tx_a, tx_b, 32'h0);
        check_both("ill_rd_rdv", 32'(rdv_a), 32'(rdv_b), 32'h1);
        check_both("ill_rd_err", 32'(err_a), 32'(err_b), 32'h1);
        wr(32'h0000_0099);
        check_both("ill_wr_err", 32'(err_a), 32'(err_b), 32'h1);
        check_both("ill_wr_stb", stb_a, stb_b, 32'h0);
        check_both("ill_no_inc", 32'(ill_a), 32'(ill_b), 32'h1);

        // W1C register
        sel(12);
        hw_set[12*DW +: DW] = 32'h0000_0008;
        tick();
        hw_set = '0;
        check_both("w1c_set", slice(q_a, 12), slice(q_b, 12), 32'h0000_0008);
        hw_set[12*DW +: DW] = 32'h0000_0008;
        wr(32'h0000_0008);
        hw_set = '0;
        check_both("w1c_set_wins", slice(q_a, 12), slice(q_b, 12), 32'h0000_0008);
        check_both("w1c_stb", stb_a, stb_b, 32'h0000_1000);
        sel(12);
        wr(32'h0000_0008);
        check_both("w1c_clr", slice(q_a, 12), slice(q_b, 12), 32'h0);

        // Simultaneous read and write of the same register
        sel(5);
        rd_en   = 1'b1;
        wr_en   = 1'b1;
        rx_data = 32'h5555_AAAA;
        tick();
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        check_both("rdwr_pre", tx_a, tx_b, 32'hA5A5_0001);
        check_both("rdwr_q5", slice(q_a, 5), slice(q_b, 5), 32'h5555_AAAA);
        check_both("rdwr_stb", stb_a, stb_b, 32'h0000_0020);
        rd();
        check("rdwr_next_a", tx_a, 32'h5555_AAAA);
        check("rdwr_next_b", tx_b, 32'h0000_0066);

        // Back-to-back burst; AUTO_INC instance walks 30,31,0,1,2
        exp_q = {32'h3000_0030, 32'h3100_0031, 32'h0000_00AA, 32'h0000_0011, 32'd70000};
        sel(30);
        rd_en   = 1'b1;
        rx_data = '0;
        while (exp_q.size() > 0) begin
            tick();
            check_both("burst_rdv", 32'(rdv_a), 32'(rdv_b), 32'h1);
            check("burst_a", tx_a, 32'h3000_0030);
            check("burst_b", tx_b, exp_q.pop_front());
        end
        rd_en = 1'b0;

        // Load coinciding with read: read uses old number, load beats increment
        sel(2);
        rd_en      = 1'b1;
        reg_num_le = 1'b1;
        rx_data    = 32'd5;
        tick();
        rd_en      = 1'b0;
        reg_num_le = 1'b0;
        check_both("le_old_num", tx_a, tx_b, 32'd70000);
        rd();
        check_both("le_new_num", tx_a, tx_b, 32'h5555_AAAA);

        // Async reset in the middle of a write
        sel(5);
        wr_en   = 1'b1;
        rx_data = 32'hDEAD_0000;
        #2 reset_n = 1'b0;
        #1;
        check_both("arst_q5", slice(q_a, 5), slice(q_b, 5), 32'h0);
        check_both("arst_q2", slice(q_a, 2), slice(q_b, 2), 32'd70000);
        check_both("arst_q12", slice(q_a, 12), slice(q_b, 12), 32'h0);
        check_both("arst_tx", tx_a, tx_b, 32'h0);
        wr_en = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        check_both("arst_no_stb", stb_a, stb_b, 32'h0);
        check_both("arst_no_err", 32'(err_a), 32'(err_b), 32'h0);
        rd();
        check_both("arst_num0", tx_a, tx_b, 32'h0000_00AA);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
